// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: load/store size codes and memory-stage state encoding.
// Also used by the decode stage to classify load/store opcodes.
package mips_defs;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b011;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } ms_state_e;

endpackage

// File: rtl/mips_lane.sv
// Byte-lane steering for aligned byte/half/word accesses: enables, store replication, load extract.
// Purely combinational (zero latency); never back-pressures.
module mips_lane
   import mips_defs::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [2:0]  sz,
   input  logic [1:0]  a,
   input  logic [31:0] T,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldval,
   output logic        misal
);

   logic [1:0]  lane;
   logic        hi;
   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      // Big-endian reverses the lane index; half-word selection flips with it.
      lane  = BIG_ENDIAN ? ~a : a;
      hi    = a[1] ^ BIG_ENDIAN;
      b     = rdata[{lane, 3'b000} +: 8];
      h     = hi ? rdata[31:16] : rdata[15:0];
      be    = 4'b0001 << lane;
      wdata = {4{T[7:0]}};
      ldval = sz[2] ? {24'b0, b} : {{24{b[7]}}, b};
      misal = 1'b0;
      case (sz[1:0])
         SZ_H[1:0]: begin
            be    = hi ? 4'b1100 : 4'b0011;
            wdata = {2{T[15:0]}};
            ldval = sz[2] ? {16'b0, h} : {{16{h[15]}}, h};
            misal = a[0];
         end
         SZ_W[1:0]: begin
            be    = 4'b1111;
            wdata = T;
            ldval = rdata;
            misal = |a;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_ms.sv
// MIPS I memory-access stage: ALU results write back after 1 edge, loads/stores after >=2 edges.
// stall holds upstream while a bus access is pending and while an aligned ld/st is being captured.
module mips_ms
   import mips_defs::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid,
   input  logic [31:0] D,
   input  logic [31:0] T,
   input  logic        ld,
   input  logic        st,
   input  logic [2:0]  sz,
   input  logic [4:0]  rd,
   output logic        stall,
   output logic        req,
   output logic        we,
   output logic [31:0] addr,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic        ack,
   input  logic [31:0] rdata,
   output logic        wb_en,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        adel,
   output logic        ades
);

   ms_state_e   state_q, state_d;
   logic        req_q, req_d, we_q, we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
   logic [3:0]  be_q, be_d;
   logic [4:0]  rd_q, rd_d, wb_reg_q, wb_reg_d;
   logic [2:0]  sz_q, sz_d;
   logic [1:0]  a_q, a_d;
   logic        wb_en_q, wb_en_d, adel_q, adel_d, ades_q, ades_d;

   logic [2:0]  lane_sz;
   logic [1:0]  lane_a;
   logic [3:0]  l_be;
   logic [31:0] l_wdata, l_ldval;
   logic        l_misal;

   // While a load is outstanding, extraction must use the captured size and offset.
   assign lane_sz = (state_q == ST_BUS) ? sz_q : sz;
   assign lane_a  = (state_q == ST_BUS) ? a_q  : D[1:0];

   mips_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
      .sz    (lane_sz),
      .a     (lane_a),
      .T     (T),
      .rdata (rdata),
      .be    (l_be),
      .wdata (l_wdata),
      .ldval (l_ldval),
      .misal (l_misal)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         sz_q      <= '0;
         a_q       <= '0;
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
         adel_q    <= 1'b0;
         ades_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         sz_q      <= sz_d;
         a_q       <= a_d;
         wb_en_q   <= wb_en_d;
         wb_reg_q  <= wb_reg_d;
         wb_data_q <= wb_data_d;
         adel_q    <= adel_d;
         ades_q    <= ades_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      sz_d      = sz_q;
      a_d       = a_q;
      wb_en_d   = 1'b0;
      wb_reg_d  = wb_reg_q;
      wb_data_d = wb_data_q;
      adel_d    = 1'b0;
      ades_d    = 1'b0;
      stall     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (valid) begin
               if (ld | st) begin
                  if (l_misal) begin
                     adel_d = ld;
                     ades_d = st;
                  end else begin
                     stall   = 1'b1;
                     state_d = ST_BUS;
                     req_d   = 1'b1;
                     we_d    = st;
                     addr_d  = {D[31:2], 2'b00};
                     be_d    = l_be;
                     wdata_d = l_wdata;
                     rd_d    = rd;
                     sz_d    = sz;
                     a_d     = D[1:0];
                  end
               end else begin
                  wb_en_d   = (rd != 5'd0);
                  wb_reg_d  = rd;
                  wb_data_d = D;
               end
            end
         end
         ST_BUS: begin
            stall = 1'b1;
            if (ack) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               if (!we_q) begin
                  wb_en_d   = (rd_q != 5'd0);
                  wb_reg_d  = rd_q;
                  wb_data_d = l_ldval;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset) stall = 1'b0;
   end

   assign req     = req_q;
   assign we      = we_q;
   assign addr    = addr_q;
   assign be      = be_q;
   assign wdata   = wdata_q;
   assign wb_en   = wb_en_q;
   assign wb_reg  = wb_reg_q;
   assign wb_data = wb_data_q;
   assign adel    = adel_q;
   assign ades    = ades_q;

endmodule

// File: doc/mips_ms.md
Name: mips_ms

Overview:
- Memory-access stage of the MIPS I pipeline. Sits directly downstream of the execute stage.
- Takes the EX result (ALU value or effective address) plus store data and a destination register. Performs aligned byte/half/word loads and stores over a simple req/ack data bus.
- Drives the register-file write port and back-pressures the upstream stages while a bus access is outstanding.

Parameters:
BIG_ENDIAN, 0, byte-lane order; 0 = little-endian (lane 0 = addr[1:0]==0), 1 = big-endian (lane 3 = addr[1:0]==0)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  EX presents an instruction this cycle
D  in  32  EX result; effective address when ld|st
T  in  32  store data (rt)
ld  in  1  instruction is a load
st  in  1  instruction is a store (ld&st never both 1)
sz  in  3  opcode[28:26]: 000 byte, 001 half, 011 word, 100 byte-unsigned, 101 half-unsigned
rd  in  5  destination register (0 = no write)
stall  out  1  upstream must hold its outputs and re-present them
req  out  1  bus request
we  out  1  bus write
addr  out  32  bus address, {D[31:2],2'b00}
be  out  4  byte enables
wdata  out  32  store data replicated to lanes
ack  in  1  bus completes current request (single cycle)
rdata  in  32  load data, valid when ack=1
wb_en  out  1  register write strobe
wb_reg  out  5  register number
wb_data  out  32  register write value
adel  out  1  load address error pulse
ades  out  1  store address error pulse

Behaviour:
- Reset (async, any state): state=IDLE; req, we, stall, wb_en, adel, ades = 0; addr, be, wdata, wb_reg, wb_data = 0.
- States: IDLE, BUS.
- IDLE, valid & !ld & !st:
  - Next edge: wb_en = (rd!=0), wb_reg=rd, wb_data=D.
  - Latency 1, full throughput.
- IDLE, valid & (ld|st), address misaligned (half with D[0]=1; word with D[1:0]!=0):
  - Next edge: adel (load) or ades (store) pulses for 1 cycle.
  - No bus cycle, wb_en=0, state stays IDLE.
- IDLE, valid & (ld|st), aligned:
  - Next edge: latch addr, be, wdata, rd, sz, D[1:0]; req=1, we=st; state=BUS; wb_en=0.
  - stall is combinational: 1 whenever state=BUS, and also in IDLE when an aligned ld/st is presented.
- be:
  - Byte: one-hot lane from D[1:0] (BIG_ENDIAN inverts lane index).
  - Half: 0011 or 1100 per D[1] (swapped when BIG_ENDIAN).
  - Word: 1111.
- wdata:
  - Byte: {4{T[7:0]}}.
  - Half: {2{T[15:0]}}.
  - Word: T.
- BUS:
  - req, addr, be, we, wdata held stable until ack.
  - On the ack edge: req=0, state=IDLE, stall drops the following cycle.
  - Load: wb_en=(rd!=0) for 1 cycle; wb_data = selected lane, sign-extended (sz[2]=0) or zero-extended (sz[2]=1).
  - Store: no write-back.
- Minimum memory-op latency is 2 edges (capture, ack-same-cycle). Each extra wait cycle adds 1.
- ack while IDLE is ignored. valid while BUS is ignored; upstream holds it via stall.
- wb_en is always a single-cycle pulse; wb_reg/wb_data hold their last value otherwise.
- Reset asserted mid-BUS: req drops immediately, and any ack arriving afterwards is ignored.

Decomposition:
- Shared package mips_defs: size codes (SZ_B=3'b000, SZ_H=3'b001, SZ_W=3'b011, SZ_BU=3'b100, SZ_HU=3'b101) and state encodings. Also usable by mips_id.
- One combinational sub-module, mips_lane, handles lane logic:
  - Inputs: sz, a[1:0], T, rdata.
  - Outputs: be, wdata, load value, misaligned flag.
  - Reused by the cache/bus bridge later.

Test Plan:
- ALU pass-through: valid, ld=st=0, D=32'h1234_5678, rd=5 -> next cycle wb_en=1, wb_reg=5, wb_data=32'h1234_5678, stall=0 throughout. With rd=0 -> wb_en=0.
- Signed byte load, LE: D=32'h0000_1003, sz=000, rdata=32'h80AA_BBCC, ack after 2 wait cycles -> addr=32'h0000_1000, be=4'b1000, req held 3 cycles, then wb_data=32'hFFFF_FF80. Repeat with sz=100 -> 32'h0000_0080.
- Half store: D=32'h0000_2002, sz=001, st=1, T=32'hDEAD_BEEF, ack same cycle -> we=1, be=4'b1100, wdata=32'hBEEF_BEEF, no wb_en; BIG_ENDIAN=1 -> be=4'b0011.
- Misaligned: word load D=32'h0000_0002 -> adel pulse, req stays 0, no wb_en. Half store D=32'h1 -> ades pulse.
- Back-pressure: word load with 3 wait cycles followed by an ALU op -> stall=1 until the ack edge, the ALU op is written back exactly once, the cycle after the load's write-back.
- Reset mid-BUS: assert reset while req=1 -> req, stall, wb_en = 0 immediately; a later ack produces no write-back.
